// File: rtl/usb_pkg.sv
// Shared constants and types for the USB full-speed transmitter.
// Request codes, PIDs, CRC16 parameters and the transmit state enum.
package usb_pkg;

    localparam logic [1:0] PKT_NONE  = 2'd0;
    localparam logic [1:0] PKT_DATA0 = 2'd1;
    localparam logic [1:0] PKT_ACK   = 2'd2;
    localparam logic [1:0] PKT_NAK   = 2'd3;

    localparam logic [7:0] SYNC_BYTE = 8'h80;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;

    // x^16+x^15+x^2+1 in bit-reflected form, since bits enter LSB first
    localparam logic [15:0] CRC16_POLY = 16'hA001;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_DATA,
        ST_CRC,
        ST_EOP_SE0,
        ST_EOP_J,
        ST_WAIT_CLR
    } tx_state_t;

    function automatic logic [7:0] pid_for(input logic [1:0] kind);
        unique case (kind)
            PKT_DATA0: return PID_DATA0;
            PKT_ACK:   return PID_ACK;
            default:   return PID_NAK;
        endcase
    endfunction

endpackage

// File: rtl/usb_crc16.sv
// Serial USB CRC16 over LSB-first data bits.
// The register holds the running remainder; the transmitter inverts it.
module usb_crc16
    import usb_pkg::*;
(
    input  logic        clk,
    input  logic        n_rst,
    input  logic        clear,
    input  logic        enable,
    input  logic        bit_in,
    output logic [15:0] crc
);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            crc <= CRC16_INIT;
        end else if (clear) begin
            crc <= CRC16_INIT;
        end else if (enable) begin
            crc <= (crc >> 1) ^ ((crc[0] ^ bit_in) ? CRC16_POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/usb_tx.sv
// USB full-speed packet transmitter: SYNC, PID, DATA0 payload, CRC16,
// bit stuffing, NRZI and EOP onto a registered differential pair.
module usb_tx
    import usb_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int MAX_PAYLOAD  = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [1:0] tx_packet,
    input  logic [6:0] buffer_occupancy,
    input  logic [7:0] tx_packet_data,
    output logic       get_tx_packet_data,
    output logic       tx_transfer_active,
    output logic       tx_error,
    output logic       dp_out,
    output logic       dm_out
);

    localparam int TW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [TW-1:0] LAST_CLK = TW'(CLKS_PER_BIT - 1);

    tx_state_t   state;
    logic [1:0]  pkt;
    logic [TW-1:0] clk_cnt;
    logic [3:0]  bit_cnt;
    logic [6:0]  byte_cnt;
    logic [7:0]  shift;
    logic [2:0]  ones;
    logic        stuff;
    logic        line;
    logic        reject;

    logic        tick;
    logic        too_long;
    logic        bit_state;
    logic        load_byte;
    logic        last_bit;
    logic        data_bit;
    logic        crc_clear;
    logic        crc_en;
    logic [15:0] crc;

    assign tick      = (clk_cnt == LAST_CLK);
    assign too_long  = {25'd0, buffer_occupancy} > 32'(MAX_PAYLOAD);
    assign bit_state = (state == ST_SYNC) || (state == ST_PID) ||
                       (state == ST_DATA) || (state == ST_CRC);
    assign load_byte = (state == ST_DATA) && (bit_cnt == 4'd0);
    assign last_bit  = (state == ST_CRC) ? (bit_cnt == 4'd15) : (bit_cnt == 4'd7);
    assign crc_clear = (state == ST_IDLE);
    assign crc_en    = tick && !stuff && (state == ST_DATA);

    // State and pointers always describe the next bit to put on the wire
    always_comb begin
        data_bit = shift[0];
        if (load_byte) begin
            data_bit = tx_packet_data[0];
        end else if (state == ST_CRC) begin
            data_bit = ~crc[bit_cnt];
        end
    end

    usb_crc16 u_crc (
        .clk    (clk),
        .n_rst  (n_rst),
        .clear  (crc_clear),
        .enable (crc_en),
        .bit_in (data_bit),
        .crc    (crc)
    );

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state              <= ST_IDLE;
            pkt                <= PKT_NONE;
            clk_cnt            <= '0;
            bit_cnt            <= '0;
            byte_cnt           <= '0;
            shift              <= '0;
            ones               <= '0;
            stuff              <= 1'b0;
            line               <= 1'b1;
            reject             <= 1'b0;
            dp_out             <= 1'b1;
            dm_out             <= 1'b0;
            tx_transfer_active <= 1'b0;
            tx_error           <= 1'b0;
            get_tx_packet_data <= 1'b0;
        end else begin
            get_tx_packet_data <= 1'b0;
            tx_error           <= reject;
            reject             <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    ones    <= '0;
                    stuff   <= 1'b0;
                    line    <= 1'b1;
                    bit_cnt <= '0;
                    clk_cnt <= LAST_CLK;
                    if (tx_packet != PKT_NONE) begin
                        if (tx_packet == PKT_DATA0 && too_long) begin
                            reject <= 1'b1;
                            state  <= ST_WAIT_CLR;
                        end else begin
                            pkt      <= tx_packet;
                            byte_cnt <= (tx_packet == PKT_DATA0) ? buffer_occupancy : '0;
                            shift    <= SYNC_BYTE;
                            state    <= ST_SYNC;
                        end
                    end
                end
                ST_WAIT_CLR: begin
                    if (tx_packet == PKT_NONE) state <= ST_IDLE;
                end
                default: begin
                    clk_cnt <= tick ? '0 : clk_cnt + TW'(1);
                    if (tick) begin
                        tx_transfer_active <= 1'b1;
                        if (stuff) begin
                            stuff  <= 1'b0;
                            line   <= ~line;
                            dp_out <= ~line;
                            dm_out <= line;
                        end else if (bit_state) begin
                            line   <= data_bit ? line : ~line;
                            dp_out <= data_bit ? line : ~line;
                            dm_out <= data_bit ? ~line : line;
                            if (!data_bit) begin
                                ones <= '0;
                            end else if (ones == 3'd5) begin
                                ones  <= '0;
                                stuff <= 1'b1;
                            end else begin
                                ones <= ones + 3'd1;
                            end
                            bit_cnt <= bit_cnt + 4'd1;
                            if (load_byte) begin
                                shift              <= {1'b0, tx_packet_data[7:1]};
                                get_tx_packet_data <= 1'b1;
                            end else begin
                                shift <= {1'b0, shift[7:1]};
                            end
                            if (last_bit) begin
                                bit_cnt <= '0;
                                unique case (state)
                                    ST_SYNC: begin
                                        shift <= pid_for(pkt);
                                        state <= ST_PID;
                                    end
                                    ST_PID: begin
                                        if (pkt != PKT_DATA0) state <= ST_EOP_SE0;
                                        else if (byte_cnt == 7'd0) state <= ST_CRC;
                                        else state <= ST_DATA;
                                    end
                                    ST_DATA: begin
                                        byte_cnt <= byte_cnt - 7'd1;
                                        if (byte_cnt == 7'd1) state <= ST_CRC;
                                    end
                                    default: state <= ST_EOP_SE0;
                                endcase
                            end
                        end else if (state == ST_EOP_SE0) begin
                            dp_out <= 1'b0;
                            dm_out <= 1'b0;
                            if (bit_cnt == 4'd1) begin
                                bit_cnt <= '0;
                                state   <= ST_EOP_J;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end else if (bit_cnt == 4'd0) begin
                            dp_out  <= 1'b1;
                            dm_out  <= 1'b0;
                            line    <= 1'b1;
                            bit_cnt <= 4'd1;
                        end else begin
                            tx_transfer_active <= 1'b0;
                            bit_cnt            <= '0;
                            state              <= ST_WAIT_CLR;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_tx.sv
// Randomized scoreboard bench for usb_tx with a bit-list reference model.
// Expected wire streams are queued by stimulus and checked by a monitor.
module tb_usb_tx;

    localparam int CPB = 8;

    typedef struct {
        bit err;
        int nclk;
    } rec_t;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [1:0] tx_packet = 2'd0;
    logic [6:0] buffer_occupancy = 7'd0;
    logic [7:0] tx_packet_data = 8'd0;
    logic       get_tx_packet_data;
    logic       tx_transfer_active;
    logic       tx_error;
    logic       dp_out;
    logic       dm_out;

    int total = 0;
    int bad = 0;
    int last_len = 0;
    bit mon_en = 1'b1;
    bit prev_err = 1'b0;
    bit in_pkt = 1'b0;

    rec_t       recs[$];
    logic [2:0] stream[$];
    logic [2:0] cap[$];
    logic [7:0] payload[$];
    logic [7:0] fifo[$];

    usb_tx #(.CLKS_PER_BIT(CPB), .MAX_PAYLOAD(64)) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .tx_packet          (tx_packet),
        .buffer_occupancy   (buffer_occupancy),
        .tx_packet_data     (tx_packet_data),
        .get_tx_packet_data (get_tx_packet_data),
        .tx_transfer_active (tx_transfer_active),
        .tx_error           (tx_error),
        .dp_out             (dp_out),
        .dm_out             (dm_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // First-word-fall-through data buffer
    always @(negedge clk) begin
        if (get_tx_packet_data && fifo.size() > 0) void'(fifo.pop_front());
        tx_packet_data   = (fifo.size() > 0) ? fifo[0] : 8'h00;
        buffer_occupancy = 7'(fifo.size());
    end

    task automatic emit_period(input logic [1:0] sym, input bit get);
        for (int c = 0; c < CPB; c++) stream.push_back({sym, get && (c == 0)});
    endtask

    task automatic build_expected(input logic [1:0] kind);
        bit bits[$];
        bit first[$];
        logic [15:0] crc;
        logic [7:0] pid;
        logic [7:0] sync;
        bit level;
        int ones;
        int n0;
        rec_t r;
        sync = 8'h80;
        pid = (kind == 2'd1) ? 8'hC3 : (kind == 2'd2) ? 8'hD2 : 8'h5A;
        for (int i = 0; i < 8; i++) begin bits.push_back(sync[i]); first.push_back(0); end
        for (int i = 0; i < 8; i++) begin bits.push_back(pid[i]); first.push_back(0); end
        if (kind == 2'd1) begin
            crc = 16'hFFFF;
            foreach (payload[j]) begin
                for (int i = 0; i < 8; i++) begin
                    bits.push_back(payload[j][i]);
                    first.push_back(i == 0);
                end
                crc ^= {8'h00, payload[j]};
                repeat (8) crc = crc[0] ? ((crc >> 1) ^ 16'hA001) : (crc >> 1);
            end
            crc = ~crc;
            for (int i = 0; i < 16; i++) begin bits.push_back(crc[i]); first.push_back(0); end
        end
        n0 = stream.size();
        level = 1'b1;
        ones = 0;
        foreach (bits[i]) begin
            if (!bits[i]) level = ~level;
            emit_period({level, ~level}, first[i]);
            if (bits[i]) begin
                ones++;
                if (ones == 6) begin
                    level = ~level;
                    emit_period({level, ~level}, 1'b0);
                    ones = 0;
                end
            end else begin
                ones = 0;
            end
        end
        emit_period(2'b00, 1'b0);
        emit_period(2'b00, 1'b0);
        emit_period(2'b10, 1'b0);
        r.err = 1'b0;
        r.nclk = stream.size() - n0;
        recs.push_back(r);
    endtask

    // Monitor: captures each packet while active and scores it on the falling edge
    always @(negedge clk) begin
        rec_t r;
        int mism;
        logic [2:0] e;
        if (!mon_en) begin
            cap.delete();
            in_pkt = 1'b0;
            prev_err = 1'b0;
        end else begin
            if (tx_error && prev_err) chk("err_width", 32'd2, 32'd1);
            if (tx_error && !prev_err) begin
                if (recs.size() == 0) begin
                    chk("unexpected_err", 32'd1, 32'd0);
                end else begin
                    r = recs.pop_front();
                    chk("err_kind", 32'(r.err), 32'd1);
                end
            end
            prev_err = tx_error;
            if (tx_transfer_active) begin
                cap.push_back({dp_out, dm_out, get_tx_packet_data});
                in_pkt = 1'b1;
            end else if (in_pkt) begin
                in_pkt = 1'b0;
                last_len = cap.size();
                if (recs.size() == 0) begin
                    chk("unexpected_pkt", 32'(cap.size()), 32'd0);
                end else begin
                    r = recs.pop_front();
                    chk("pkt_kind", 32'(r.err), 32'd0);
                    chk("pkt_len", 32'(cap.size()), 32'(r.nclk));
                    mism = -1;
                    for (int i = 0; i < r.nclk; i++) begin
                        e = (stream.size() > 0) ? stream.pop_front() : 3'b111;
                        if (mism < 0 && (i >= cap.size() || cap[i] !== e)) begin
                            mism = i;
                            $display("FAIL wire at clk %0d: got %b want %b (dp dm get)",
                                     i, (i < cap.size()) ? cap[i] : 3'bxxx, e);
                        end
                    end
                    total++;
                    if (mism >= 0) bad++;
                end
                cap.delete();
            end
        end
    end

    task automatic send(input logic [1:0] kind);
        bit done;
        foreach (payload[i]) fifo.push_back(payload[i]);
        @(negedge clk);
        build_expected(kind);
        tx_packet = kind;
        @(negedge clk);
        chk("start_early", 32'(tx_transfer_active), 32'd0);
        @(negedge clk);
        chk("start", 32'(tx_transfer_active), 32'd1);
        done = 1'b0;
        for (int i = 0; i < 20000 && !done; i++) begin
            @(negedge clk);
            if (!tx_transfer_active) done = 1'b1;
        end
        chk("end_timeout", 32'(done), 32'd1);
        tx_packet = 2'd0;
        chk("drain", 32'(fifo.size()), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic rand_payload(input int len);
        payload.delete();
        for (int i = 0; i < len; i++) payload.push_back(8'($urandom));
    endtask

    initial begin
        bit ok;
        int pops;
        logic [1:0] k;

        repeat (2) @(negedge clk);
        chk("rst_dp", 32'(dp_out), 32'd1);
        chk("rst_dm", 32'(dm_out), 32'd0);
        chk("rst_active", 32'(tx_transfer_active), 32'd0);
        chk("rst_err", 32'(tx_error), 32'd0);
        chk("rst_get", 32'(get_tx_packet_data), 32'd0);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        payload.delete();
        send(2'd2);
        chk("ack_len", 32'(last_len), 32'd152);

        payload.delete();
        send(2'd1);
        chk("zlp_len", 32'(last_len), 32'd280);

        payload.delete();
        payload.push_back(8'hFF);
        send(2'd1);

        // Oversized request is refused and must not retrigger while held
        for (int i = 0; i < 65; i++) fifo.push_back(8'($urandom));
        @(negedge clk);
        recs.push_back('{err: 1'b1, nclk: 0});
        tx_packet = 2'd1;
        @(negedge clk);
        chk("err_early", 32'(tx_error), 32'd0);
        @(negedge clk);
        chk("err_pulse", 32'(tx_error), 32'd1);
        ok = 1'b1;
        fifo.delete();
        fifo.push_back(8'h12);
        fifo.push_back(8'h34);
        repeat (20) begin
            @(negedge clk);
            if (tx_transfer_active || !dp_out || dm_out || get_tx_packet_data) ok = 1'b0;
        end
        chk("reject_idle", 32'(ok), 32'd1);
        tx_packet = 2'd0;
        @(negedge clk);
        fifo.delete();
        @(negedge clk);
        rand_payload(2);
        send(2'd1);

        for (int n = 0; n < 6; n++) begin
            k = 2'($urandom_range(1, 3));
            if (k == 2'd1) rand_payload($urandom_range(0, 16));
            else payload.delete();
            send(k);
        end

        payload.delete();
        for (int i = 0; i < 10; i++) payload.push_back(8'hFF);
        send(2'd1);

        rand_payload(64);
        send(2'd1);

        // Reset in the middle of the second payload byte
        mon_en = 1'b0;
        rand_payload(4);
        foreach (payload[i]) fifo.push_back(payload[i]);
        @(negedge clk);
        tx_packet = 2'd1;
        pops = 0;
        for (int i = 0; i < 2000 && pops < 2; i++) begin
            @(negedge clk);
            if (get_tx_packet_data) pops++;
        end
        chk("mid_pops", 32'(pops), 32'd2);
        repeat (4 * CPB) @(negedge clk);
        n_rst = 1'b0;
        @(negedge clk);
        chk("mid_dp", 32'(dp_out), 32'd1);
        chk("mid_dm", 32'(dm_out), 32'd0);
        chk("mid_active", 32'(tx_transfer_active), 32'd0);
        chk("mid_err", 32'(tx_error), 32'd0);
        chk("mid_get", 32'(get_tx_packet_data), 32'd0);
        tx_packet = 2'd0;
        n_rst = 1'b1;
        fifo.delete();
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
        payload.delete();
        send(2'd2);
        send(2'd3);

        repeat (5) @(negedge clk);
        chk("leftover_recs", 32'(recs.size()), 32'd0);
        chk("leftover_stream", 32'(stream.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
